// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Purpose:
//   Fetches one instruction at a time over a simple AXI-lite style read
//   channel and offers it to the decode stage. After each handoff it waits
//   for the commit stage to supply the next PC before fetching again, so at
//   most one instruction is ever in flight.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   araddr, arvalid   read address channel (out), arready (in)
//   rdata, rresp,
//   rvalid            read data channel (in), rready (out)
//   ifu_valid,
//   ifu_data,
//   fetch_err         instruction offer to IDU: {inst, pc} plus error flag
//   idu_ready         IDU accepts the offer
//   pc_update_valid,
//   next_pc           commit-stage redirect, honoured only while waiting
//   perf_fetch_cnt    number of instructions handed to IDU (wraps)
// -----------------------------------------------------------------------------
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic        ifu_valid,
   output logic [63:0] ifu_data,
   input  logic        idu_ready,
   output logic        fetch_err,
   input  logic        pc_update_valid,
   input  logic [31:0] next_pc,
   output logic [31:0] perf_fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_R,
      S_SEND,
      S_WAIT_PC
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_err;
   logic [31:0] r_perf_cnt;

   logic        w_arvalid;
   logic        w_rready;
   logic        w_ifu_valid;
   logic        w_capture;
   logic        w_handoff;
   logic        w_pc_load;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and control decode. The three handshake outputs depend on
   // r_state alone, so no input reaches them combinationally.
   always_comb begin
      w_state_next = r_state;
      w_arvalid    = 1'b0;
      w_rready     = 1'b0;
      w_ifu_valid  = 1'b0;
      w_capture    = 1'b0;
      w_handoff    = 1'b0;
      w_pc_load    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_FETCH;
         end
         S_FETCH: begin
            w_arvalid = 1'b1;
            if (arready) begin
               w_state_next = S_WAIT_R;
            end
         end
         S_WAIT_R: begin
            // rready is only raised here, so a response presented early
            // (while the address is still pending) is left untouched.
            w_rready = 1'b1;
            if (rvalid) begin
               w_capture    = 1'b1;
               w_state_next = S_SEND;
            end
         end
         S_SEND: begin
            w_ifu_valid = 1'b1;
            if (idu_ready) begin
               w_handoff    = 1'b1;
               w_state_next = S_WAIT_PC;
            end
         end
         S_WAIT_PC: begin
            // Redirects outside this state are deliberately dropped.
            if (pc_update_valid) begin
               w_pc_load    = 1'b1;
               w_state_next = S_FETCH;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_inst     <= 32'h0;
         r_err      <= 1'b0;
         r_perf_cnt <= 32'h0;
      end else begin
         if (w_capture) begin
            r_inst <= rdata;
            r_err  <= (rresp != 2'b00);
         end
         if (w_handoff) begin
            // Natural 32-bit wrap from all-ones back to zero.
            r_perf_cnt <= r_perf_cnt + 32'd1;
         end
         if (w_pc_load) begin
            // Taken as given: no alignment check or masking.
            r_pc <= next_pc;
         end
      end
   end

   assign araddr         = r_pc;
   assign arvalid        = w_arvalid;
   assign rready         = w_rready;
   assign ifu_valid      = w_ifu_valid;
   // inst_reg and err_reg only change on capture, so the offer stays stable
   // for as long as the IDU stalls.
   assign ifu_data       = {r_inst, r_pc};
   assign fetch_err      = r_err;
   assign perf_fetch_cnt = r_perf_cnt;

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu
//
// The bench plays memory, decode stage and commit stage. Expected values come
// from a transaction-level view: each fetch must present the address the bench
// last committed, deliver {returned word, that address}, flag any non-zero
// response, and bump the handoff count by one.
// -----------------------------------------------------------------------------
module tb_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        ifu_valid;
   logic [63:0] ifu_data;
   logic        idu_ready;
   logic        fetch_err;
   logic        pc_update_valid;
   logic [31:0] next_pc;
   logic [31:0] perf_fetch_cnt;

   int          checks;
   int          errors;
   logic [31:0] model_cnt;
   logic [31:0] model_pc;

   ifu #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .araddr          (araddr),
      .arvalid         (arvalid),
      .arready         (arready),
      .rdata           (rdata),
      .rresp           (rresp),
      .rvalid          (rvalid),
      .rready          (rready),
      .ifu_valid       (ifu_valid),
      .ifu_data        (ifu_data),
      .idu_ready       (idu_ready),
      .fetch_err       (fetch_err),
      .pc_update_valid (pc_update_valid),
      .next_pc         (next_pc),
      .perf_fetch_cnt  (perf_fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;     // address this fetch must use
      logic [31:0] rd;       // word returned by memory
      logic [1:0]  rr;       // response code
      int          ar_d;     // cycles arready held low
      int          r_d;      // cycles before rvalid
      int          idu_d;    // cycles of IDU backpressure
      int          upd_d;    // cycles before the commit pulse
      logic        spur;     // pulse junk redirects outside S_WAIT_PC
      logic [31:0] npc;      // committed next PC
      logic [63:0] exp_data; // required ifu_data
      logic        exp_err;  // required fetch_err
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait (bounded) for an address request and accept it; leaves DUT waiting
   // for read data.
   task automatic issue_addr(input logic [31:0] addr);
      int n;
      n = 0;
      while (arvalid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("arvalid_seen", {63'h0, arvalid}, 64'h1);
      chk("araddr", {32'h0, araddr}, {32'h0, addr});
      arready = 1'b1;
      step();
      arready = 1'b0;
   endtask

   // One complete fetch transaction with the given handshake delays.
   task automatic run_fetch(input vec_t v, input string tag);
      int n;
      n = 0;
      while (arvalid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("arvalid_seen", {63'h0, arvalid}, 64'h1);
      chk("araddr", {32'h0, araddr}, {32'h0, v.addr});
      chk("rready_in_fetch", {63'h0, rready}, 64'h0);
      for (int i = 0; i < v.ar_d; i++) begin
         // Early response while the address is still pending must be ignored.
         rvalid = 1'b1;
         rdata  = 32'hBAD0_0000 | i;
         rresp  = 2'b11;
         if (v.spur) begin
            pc_update_valid = 1'b1;
            next_pc         = 32'h1234_0000;
         end
         step();
         pc_update_valid = 1'b0;
         chk("arvalid_hold", {63'h0, arvalid}, 64'h1);
         chk("araddr_hold", {32'h0, araddr}, {32'h0, v.addr});
         chk("rready_low", {63'h0, rready}, 64'h0);
      end
      rvalid  = 1'b0;
      rresp   = 2'b00;
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rready_wait_r", {63'h0, rready}, 64'h1);
      chk("arvalid_wait_r", {63'h0, arvalid}, 64'h0);
      for (int i = 0; i < v.r_d; i++) begin
         if (v.spur) begin
            pc_update_valid = 1'b1;
            next_pc         = 32'h1234_0000;
         end
         step();
         pc_update_valid = 1'b0;
         chk("rready_hold", {63'h0, rready}, 64'h1);
      end
      rvalid = 1'b1;
      rdata  = v.rd;
      rresp  = v.rr;
      if (v.spur) begin
         pc_update_valid = 1'b1;
         next_pc         = 32'h1234_0000;
      end
      step();
      rvalid          = 1'b0;
      pc_update_valid = 1'b0;
      rdata           = 32'h5555_AAAA;
      rresp           = 2'b11;
      chk("ifu_valid", {63'h0, ifu_valid}, 64'h1);
      chk("ifu_data", ifu_data, v.exp_data);
      chk("fetch_err", {63'h0, fetch_err}, {63'h0, v.exp_err});
      chk("rready_send", {63'h0, rready}, 64'h0);
      for (int i = 0; i < v.idu_d; i++) begin
         step();
         chk("bp_ifu_valid", {63'h0, ifu_valid}, 64'h1);
         chk("bp_ifu_data", ifu_data, v.exp_data);
         chk("bp_fetch_err", {63'h0, fetch_err}, {63'h0, v.exp_err});
         chk("bp_perf_cnt", {32'h0, perf_fetch_cnt}, {32'h0, model_cnt});
      end
      idu_ready = 1'b1;
      step();
      idu_ready = 1'b0;
      model_cnt = model_cnt + 32'd1;
      chk("perf_cnt", {32'h0, perf_fetch_cnt}, {32'h0, model_cnt});
      chk("ifu_valid_low", {63'h0, ifu_valid}, 64'h0);
      for (int i = 0; i < v.upd_d; i++) begin
         step();
         chk("arvalid_wait_pc", {63'h0, arvalid}, 64'h0);
      end
      pc_update_valid = 1'b1;
      next_pc         = v.npc;
      step();
      pc_update_valid = 1'b0;
      next_pc         = 32'hFFFF_0000;
      chk("arvalid_redirect", {63'h0, arvalid}, 64'h1);
      chk("araddr_redirect", {32'h0, araddr}, {32'h0, v.npc});
      $display("txn %s addr=%h rdata=%h rresp=%0d data=%h err=%0b cnt=%0d next=%h",
               tag, v.addr, v.rd, v.rr, ifu_data, fetch_err, perf_fetch_cnt, v.npc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_arvalid"}, {63'h0, arvalid}, 64'h0);
      chk({tag, "_rready"}, {63'h0, rready}, 64'h0);
      chk({tag, "_ifu_valid"}, {63'h0, ifu_valid}, 64'h0);
      chk({tag, "_ifu_data"}, ifu_data, {32'h0, RESET_PC});
      chk({tag, "_fetch_err"}, {63'h0, fetch_err}, 64'h0);
      chk({tag, "_perf_cnt"}, {32'h0, perf_fetch_cnt}, 64'h0);
   endtask

   initial begin
      vec_t v;
      checks          = 0;
      errors          = 0;
      model_cnt       = 32'h0;
      rst             = 1'b1;
      arready         = 1'b0;
      rdata           = 32'h0;
      rresp           = 2'b00;
      rvalid          = 1'b0;
      idu_ready       = 1'b0;
      pc_update_valid = 1'b0;
      next_pc         = 32'h0;

      //             addr          rd            rr ar r idu upd spur npc           exp_data                  err
      vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 0, 1'b0, 32'h8000_0004, 64'h0000_0413_8000_0000, 1'b0};
      vecs[1] = '{32'h8000_0004, 32'h0010_0093, 2'b00, 2, 1, 5, 1, 1'b0, 32'h8000_0100, 64'h0010_0093_8000_0004, 1'b0};
      vecs[2] = '{32'h8000_0100, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 1'b0, 32'h8000_0102, 64'hDEAD_BEEF_8000_0100, 1'b1};
      vecs[3] = '{32'h8000_0102, 32'h1234_5678, 2'b00, 1, 3, 2, 0, 1'b1, 32'h8000_0300, 64'h1234_5678_8000_0102, 1'b0};
      vecs[4] = '{32'h8000_0300, 32'hFFFF_FFFF, 2'b01, 3, 0, 1, 2, 1'b1, 32'h0000_0000, 64'hFFFF_FFFF_8000_0300, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'hCAFE_F00D, 2'b11, 0, 2, 0, 3, 1'b0, 32'h8000_0000, 64'hCAFE_F00D_0000_0000, 1'b1};

      // Reset state, during reset and the first cycle after release.
      step();
      step();
      check_reset_outputs("in_reset");
      rst = 1'b0;
      check_reset_outputs("after_reset");

      for (int i = 0; i < 6; i++) begin
         run_fetch(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting for read data: transfer abandoned.
      issue_addr(RESET_PC);
      chk("midr_rready", {63'h0, rready}, 64'h1);
      rst = 1'b1;
      step();
      model_cnt = 32'h0;
      check_reset_outputs("rst_wait_r");
      rst = 1'b0;
      $display("txn rst_in_wait_r cnt=%0d arvalid=%0b rready=%0b", perf_fetch_cnt, arvalid, rready);
      v = '{RESET_PC, 32'h0000_0013, 2'b00, 0, 0, 0, 0, 1'b0, 32'h8000_0010, 64'h0000_0013_8000_0000, 1'b0};
      run_fetch(v, "post_rst_r");

      // Reset while offering to IDU.
      issue_addr(32'h8000_0010);
      rvalid = 1'b1;
      rdata  = 32'h0BAD_0BAD;
      rresp  = 2'b10;
      step();
      rvalid = 1'b0;
      rresp  = 2'b00;
      chk("mids_ifu_valid", {63'h0, ifu_valid}, 64'h1);
      rst = 1'b1;
      step();
      model_cnt = 32'h0;
      check_reset_outputs("rst_send");
      rst = 1'b0;
      $display("txn rst_in_send cnt=%0d ifu_valid=%0b", perf_fetch_cnt, ifu_valid);
      model_pc = RESET_PC;

      // Randomized transactions against the transaction-level model.
      for (int i = 0; i < 30; i++) begin
         v.addr  = model_pc;
         v.rd    = $urandom;
         v.rr    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.ar_d  = $urandom_range(0, 3);
         v.r_d   = $urandom_range(0, 3);
         v.idu_d = $urandom_range(0, 4);
         v.upd_d = $urandom_range(0, 3);
         v.spur  = 1'($urandom_range(0, 1));
         v.npc   = $urandom;
         v.exp_data = {v.rd, model_pc};
         v.exp_err  = (v.rr != 2'b00);
         run_fetch(v, $sformatf("rand%0d", i));
         model_pc = v.npc;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
